// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
// Sprite-memory DMA sequencer ($4014 write). Halts the CPU and copies one
// CPU page into the PPU OAM through its single write port, alternating
// CPU-bus reads (get cycles, ph=0) and OAM writes (put cycles, ph=1).
// Everything advances only on CPU clock-enable cycles.
//
// Build option: define OAM_DMA_RESTART_EN to let a start strobe during a
// transfer abort it and restart from the new page/base. When undefined, a
// start while busy is ignored.
//
// Ports:
//   clk, rst          master clock, synchronous active-high reset
//   clk_en            CPU-cycle enable
//   start             $4014 write strobe (sampled with clk_en)
//   page, oam_base    source page and OAMADDR, captured with start
//   cpu_halt, busy    CPU stall request / transfer in progress
//   bus_addr, bus_re  CPU-bus read address and strobe
//   bus_rdata         CPU-bus read data, valid while bus_re is high
//   oam_addr, oam_we, oam_wdata   OAM write port
//   done              one-clk pulse after the final write
// ---------------------------------------------------------------------------
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start
// S_HALT  | first CPU cycle with the CPU halted
// S_ALIGN | extra halt cycle so the first read lands on a get cycle
// S_READ  | get cycle: read {page, idx} from the CPU bus into the latch
// S_WRITE | put cycle: write the latch to OAM at oam_base + idx
// ---------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter int PAGE_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        start,
    input  logic [7:0]  page,
    input  logic [7:0]  oam_base,
    output logic        cpu_halt,
    output logic        busy,
    output logic [15:0] bus_addr,
    output logic        bus_re,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(PAGE_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t     state, state_nxt;
    logic       ph;
    logic [7:0] idx, idx_nxt;
    logic [7:0] page_q, page_nxt;
    logic [7:0] base_q, base_nxt;
    logic [7:0] data_q, data_nxt;
    logic       done_nxt;

    // Next-state values for a CPU cycle; only committed when clk_en is high.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        page_nxt  = page_q;
        base_nxt  = base_q;
        data_nxt  = data_q;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_HALT;
                    page_nxt  = page;
                    base_nxt  = oam_base;
                    idx_nxt   = 8'd0;
                end
            end
            // ph is the phase of the current (HALT) cycle; the next cycle is
            // a get only when this one is a put.
            S_HALT:  state_nxt = ph ? S_READ : S_ALIGN;
            S_ALIGN: state_nxt = S_READ;
            S_READ: begin
                data_nxt  = bus_rdata;
                state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (idx == LAST_IDX) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    state_nxt = S_READ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
`ifdef OAM_DMA_RESTART_EN
        // A restart abandons the running transfer without signalling done.
        if (state != S_IDLE && start) begin
            state_nxt = S_HALT;
            page_nxt  = page;
            base_nxt  = oam_base;
            idx_nxt   = 8'd0;
            done_nxt  = 1'b0;
        end
`endif
    end

    // Outputs are registered as a decode of the next state so they are
    // valid for the whole CPU cycle spent in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ph        <= 1'b0;
            idx       <= 8'd0;
            page_q    <= 8'd0;
            base_q    <= 8'd0;
            data_q    <= 8'd0;
            cpu_halt  <= 1'b0;
            busy      <= 1'b0;
            bus_addr  <= 16'd0;
            bus_re    <= 1'b0;
            oam_addr  <= 8'd0;
            oam_we    <= 1'b0;
            oam_wdata <= 8'd0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clk_en) begin
                ph        <= ~ph;
                state     <= state_nxt;
                idx       <= idx_nxt;
                page_q    <= page_nxt;
                base_q    <= base_nxt;
                data_q    <= data_nxt;
                done      <= done_nxt;
                busy      <= (state_nxt != S_IDLE);
                cpu_halt  <= (state_nxt != S_IDLE);
                bus_re    <= (state_nxt == S_READ);
                bus_addr  <= (state_nxt == S_READ) ? {page_nxt, idx_nxt} : 16'd0;
                oam_we    <= (state_nxt == S_WRITE);
                oam_addr  <= (state_nxt == S_WRITE) ? (base_nxt + idx_nxt) : 8'd0;
                oam_wdata <= (state_nxt == S_WRITE) ? data_nxt : 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_ctrl
// Self-checking bench for oam_dma_ctrl. A CPU-memory array feeds bus_rdata,
// an OAM array captures qualified writes, and expected OAM contents and halt
// lengths are computed from the transfer rules (byte i of the page lands at
// OAM[(base+i) mod 256]; halt = 1 + 2*256 CPU cycles, +1 when HALT is a get).
// ---------------------------------------------------------------------------
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  page = 8'd0;
    logic [7:0]  oam_base = 8'd0;
    logic        cpu_halt, busy, bus_re, oam_we, done;
    logic [15:0] bus_addr;
    logic [7:0]  bus_rdata, oam_addr, oam_wdata;

    oam_dma_ctrl #(.PAGE_BYTES(256)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .page(page),
        .oam_base(oam_base), .cpu_halt(cpu_halt), .busy(busy),
        .bus_addr(bus_addr), .bus_re(bus_re), .bus_rdata(bus_rdata),
        .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata),
        .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] cpu_mem [65536];
    assign bus_rdata = cpu_mem[bus_addr];

    // Observation state, written only by the monitor.
    logic [7:0] oam_mem [256];
    int         wr_cnt [256];
    int cyc = 0, halt_cpu = 0, halt_clk = 0, quiet_halt = 0;
    int done_clk = 0, wr_total = 0;

    int n_cmp = 0, n_bad = 0;
    int en_div = 1;

    // clk_en generator: one enabled clk in every en_div.
    initial begin
        int en_ctr;
        en_ctr = 0;
        forever begin
            @(negedge clk);
            en_ctr = (en_ctr + 1) % en_div;
            clk_en = (en_ctr == 0);
        end
    end

    initial begin
        for (int a = 0; a < 256; a++) begin
            oam_mem[a] = 8'd0;
            wr_cnt[a]  = 0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                cyc = 0;
            end else begin
                if (done) done_clk++;
                if (cpu_halt) halt_clk++;
                if (clk_en) begin
                    if (cpu_halt) halt_cpu++;
                    if (cpu_halt && !bus_re && !oam_we) quiet_halt++;
                    if (oam_we) begin
                        oam_mem[oam_addr] = oam_wdata;
                        wr_cnt[oam_addr]++;
                        wr_total++;
                    end
                    cyc++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // want_get: 1 = HALT on a get cycle, 0 = on a put cycle, 2 = any.
    // cyc parity equals the phase of the cycle in which start is sampled.
    task automatic do_start(input logic [7:0] pg, input logic [7:0] base,
                            input int want_get, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk); #1;
            if (clk_en && (want_get == 2 || (cyc % 2) == (want_get == 1 ? 1 : 0)))
                ok = 1'b1;
        end
        if (ok) begin
            start = 1'b1; page = pg; oam_base = base;
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        int base;
        base = wr_total;
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk);
            if (wr_total - base >= n) ok = 1'b1;
        end
    endtask

    task automatic fill_page(input logic [7:0] pg, input bit pattern);
        for (int i = 0; i < 256; i++)
            cpu_mem[{pg, 8'(i)}] = pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("FAIL reset_halt: got %b want 0", cpu_halt); end
        n_cmp++; if (bus_re !== 1'b0) begin n_bad++; $display("FAIL reset_bus_re: got %b want 0", bus_re); end
        n_cmp++; if (oam_we !== 1'b0) begin n_bad++; $display("FAIL reset_oam_we: got %b want 0", oam_we); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (bus_addr !== 16'd0) begin n_bad++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        n_cmp++; if (oam_addr !== 8'd0) begin n_bad++; $display("FAIL reset_oam_addr: got %h want 0", oam_addr); end
        n_cmp++; if (oam_wdata !== 8'd0) begin n_bad++; $display("FAIL reset_oam_wdata: got %h want 0", oam_wdata); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One complete transfer checked against the model.
    task automatic run_transfer(input string nm, input logic [7:0] pg,
                                input logic [7:0] base, input int want_get);
        int h0, hc0, q0, d0, exp_halt;
        int c0 [256];
        bit ok;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) c0[i] = wr_cnt[i];
        h0 = halt_cpu; hc0 = halt_clk; q0 = quiet_halt; d0 = done_clk;
        exp_halt = 513 + want_get;
        do_start(pg, base, want_get, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_start: no start slot found", nm); end
        wait_idle(600 * en_div + 50, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_timeout: busy still %b", nm, busy); end
        repeat (8) @(negedge clk);
        n_cmp++; if (halt_cpu - h0 !== exp_halt) begin n_bad++; $display("FAIL %s_halt_cycles: got %0d want %0d", nm, halt_cpu - h0, exp_halt); end
        n_cmp++; if (halt_clk - hc0 !== en_div * exp_halt) begin n_bad++; $display("FAIL %s_halt_clks: got %0d want %0d", nm, halt_clk - hc0, en_div * exp_halt); end
        n_cmp++; if (quiet_halt - q0 !== 1 + want_get) begin n_bad++; $display("FAIL %s_halt_align: got %0d want %0d", nm, quiet_halt - q0, 1 + want_get); end
        n_cmp++; if (done_clk - d0 !== 1) begin n_bad++; $display("FAIL %s_done: got %0d pulses want 1", nm, done_clk - d0); end
        for (int i = 0; i < 256; i++) begin
            a = 8'(base + 8'(i));
            n_cmp++;
            if (oam_mem[a] !== cpu_mem[{pg, 8'(i)}] || wr_cnt[a] - c0[a] !== 1) begin
                n_bad++;
                $display("FAIL %s_oam[%02h]: got %02h x%0d want %02h x1", nm, a,
                         oam_mem[a], wr_cnt[a] - c0[a], cpu_mem[{pg, 8'(i)}]);
            end
        end
    endtask

    task automatic test_put_halt();
        en_div = 1;
        fill_page(8'h02, 1'b1);
        run_transfer("put_halt", 8'h02, 8'h00, 0);
    endtask

    task automatic test_get_halt();
        en_div = 1;
        run_transfer("get_halt", 8'h02, 8'h00, 1);
    endtask

    task automatic test_wrap();
        en_div = 1;
        fill_page(8'h03, 1'b0);
        run_transfer("wrap", 8'h03, 8'hFC, $urandom_range(0, 1));
        n_cmp++; if (oam_mem[8'hFC] !== cpu_mem[16'h0300]) begin n_bad++; $display("FAIL wrap_first: got %02h want %02h", oam_mem[8'hFC], cpu_mem[16'h0300]); end
        n_cmp++; if (oam_mem[8'h00] !== cpu_mem[16'h0304]) begin n_bad++; $display("FAIL wrap_byte4: got %02h want %02h", oam_mem[8'h00], cpu_mem[16'h0304]); end
        n_cmp++; if (oam_mem[8'hFB] !== cpu_mem[16'h03FF]) begin n_bad++; $display("FAIL wrap_last: got %02h want %02h", oam_mem[8'hFB], cpu_mem[16'h03FF]); end
    endtask

    task automatic test_sparse_en();
        logic [7:0] pg;
        pg = 8'($urandom_range(8, 255));
        en_div = 4;
        fill_page(pg, 1'b0);
        run_transfer("sparse_en", pg, 8'($urandom), $urandom_range(0, 1));
        en_div = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int d0;
        int c0 [256];
        bit ok;
        logic [7:0] pg;
        pg = 8'h40;
        en_div = 1;
        fill_page(pg, 1'b0);
        for (int i = 0; i < 256; i++) c0[i] = wr_cnt[i];
        d0 = done_clk;
        do_start(pg, 8'h00, 2, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_mid_start: no start slot found"); end
        wait_writes(100, 400, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_mid_timeout: writes did not reach 100"); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_cmp++; if (cpu_halt !== 1'b0) begin n_bad++; $display("FAIL rst_mid_halt: got %b want 0", cpu_halt); end
        n_cmp++; if (oam_we !== 1'b0) begin n_bad++; $display("FAIL rst_mid_we: got %b want 0", oam_we); end
        rst = 1'b0;
        repeat (600) @(negedge clk);
        n_cmp++; if (done_clk - d0 !== 0) begin n_bad++; $display("FAIL rst_mid_done: got %0d pulses want 0", done_clk - d0); end
        for (int i = 0; i < 256; i++) begin
            n_cmp++;
            if (i < 100) begin
                if (wr_cnt[i] - c0[i] !== 1 || oam_mem[i] !== cpu_mem[{pg, 8'(i)}]) begin
                    n_bad++;
                    $display("FAIL rst_mid_oam[%02h]: got %02h x%0d want %02h x1", i, oam_mem[i], wr_cnt[i] - c0[i], cpu_mem[{pg, 8'(i)}]);
                end
            end else if (wr_cnt[i] - c0[i] !== 0) begin
                n_bad++;
                $display("FAIL rst_mid_untouched[%02h]: got x%0d writes want x0", i, wr_cnt[i] - c0[i]);
            end
        end
    endtask

    task automatic test_restart();
        int h0, d0, exp_halt;
        bit ok;
        logic [7:0] pa, pb, base, expd;
        pa = 8'h06; pb = 8'h05; base = 8'($urandom);
        en_div = 1;
        fill_page(pa, 1'b0);
        fill_page(pb, 1'b0);
        h0 = halt_cpu; d0 = done_clk;
        do_start(pa, base, 0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL restart_start: no start slot found"); end
        wait_writes(50, 200, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL restart_timeout: writes did not reach 50"); end
        start = 1'b1; page = pb; oam_base = base;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(1300, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL restart_idle_timeout: busy still %b", busy); end
        repeat (4) @(negedge clk);
`ifdef OAM_DMA_RESTART_EN
        exp_halt = 102 + 513;
`else
        exp_halt = 513;
`endif
        n_cmp++; if (halt_cpu - h0 !== exp_halt) begin n_bad++; $display("FAIL restart_halt_cycles: got %0d want %0d", halt_cpu - h0, exp_halt); end
        n_cmp++; if (done_clk - d0 !== 1) begin n_bad++; $display("FAIL restart_done: got %0d pulses want 1", done_clk - d0); end
        for (int i = 0; i < 256; i++) begin
`ifdef OAM_DMA_RESTART_EN
            expd = cpu_mem[{pb, 8'(i)}];
`else
            expd = cpu_mem[{pa, 8'(i)}];
`endif
            n_cmp++;
            if (oam_mem[8'(base + 8'(i))] !== expd) begin
                n_bad++;
                $display("FAIL restart_oam[%02h]: got %02h want %02h", 8'(base + 8'(i)), oam_mem[8'(base + 8'(i))], expd);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pg;
        for (int k = 0; k < 3; k++) begin
            en_div = $urandom_range(1, 3);
            pg = 8'($urandom_range(16, 255));
            fill_page(pg, 1'b0);
            run_transfer("random", pg, 8'($urandom), $urandom_range(0, 1));
        end
        en_div = 1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_put_halt();
        test_get_halt();
        test_wrap();
        test_sparse_en();
        test_reset_mid();
        test_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
